// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status in, stage enables/flushes and
// status out.
// Handshake semantics: there is no valid/ready pair. Every input is a level
// sampled on each rising clk edge. Every output is a level that is valid for
// the current cycle, and the pipeline consumes it on that same edge.
// The dbg_* fields expose the controller's registered state so checkers can
// bind to it.
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  ex_rd;
  logic        ex_memread;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        mem_req;
  logic        dmem_ack;

  logic        pc_en;
  logic        if_id_en;
  logic        id_ex_en;
  logic        ex_mem_en;
  logic        mem_wb_en;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        ex_mem_flush;
  logic        md_busy;
  logic        mem_err;
  logic [31:0] stall_cycles;

  logic [0:0]  dbg_state;
  logic [3:0]  dbg_md_cnt;
  logic [7:0]  dbg_wait_cnt;

  // The pipeline side drives status and consumes the controls.
  modport master (
    output id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, ex_md_start,
           mem_req, dmem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_busy, mem_err,
           stall_cycles, dbg_state, dbg_md_cnt, dbg_wait_cnt
  );

  // The controller side consumes the status and drives the controls.
  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_memread, ex_branch_taken, ex_md_start,
           mem_req, dmem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, md_busy, mem_err,
           stall_cycles, dbg_state, dbg_md_cnt, dbg_wait_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Hazard priority, highest first:
//   1. data-memory wait
//   2. mul/div occupancy of EX
//   3. taken-branch redirect
//   4. load-use
// Stage controls are combinational from the registered state and the inputs.
module pipe_hazard_ctrl #(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rstn,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);
  localparam logic [3:0] MD_LOAD     = 4'(MD_LATENCY - 1);
  localparam bit         MD_MULTI    = (MD_LATENCY > 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_md_cnt;
  logic [3:0]  w_md_cnt_nxt;
  logic [7:0]  r_wait_cnt;
  logic        r_mem_err;
  logic [31:0] r_stall_cycles;

  logic w_mem_pending;
  logic w_timeout;
  logic w_mem_stall;
  logic w_load_use;

  logic w_pc_en;
  logic w_if_id_en;
  logic w_id_ex_en;
  logic w_ex_mem_en;
  logic w_mem_wb_en;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_mem_flush;

  // A memory access still waiting for its ack. When the wait budget is used
  // up, the access is treated as acknowledged so the pipeline cannot hang.
  assign w_mem_pending = bus.mem_req & ~bus.dmem_ack;
  assign w_timeout     = w_mem_pending & (r_wait_cnt == TIMEOUT_CNT);
  assign w_mem_stall   = w_mem_pending & (r_wait_cnt != TIMEOUT_CNT);

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign w_load_use = bus.ex_memread & (bus.ex_rd != 5'd0) &
                      ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));

  // Next-state and stage controls, resolved in hazard-priority order.
  always_comb begin
    w_state_nxt    = r_state;
    w_md_cnt_nxt   = r_md_cnt;
    w_pc_en        = 1'b1;
    w_if_id_en     = 1'b1;
    w_id_ex_en     = 1'b1;
    w_ex_mem_en    = 1'b1;
    w_mem_wb_en    = 1'b1;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    if (!rstn) begin
      w_pc_en        = 1'b0;
      w_if_id_en     = 1'b0;
      w_id_ex_en     = 1'b0;
      w_ex_mem_en    = 1'b0;
      w_mem_wb_en    = 1'b0;
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_ex_mem_flush = 1'b1;
    end else if (w_mem_stall) begin
      // Full freeze: the FSM and md_cnt hold, so a stall inside a mul/div
      // does not consume any of its occupancy.
      w_pc_en     = 1'b0;
      w_if_id_en  = 1'b0;
      w_id_ex_en  = 1'b0;
      w_ex_mem_en = 1'b0;
      w_mem_wb_en = 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (bus.ex_md_start) begin
            // A single-cycle mul/div behaves like any ALU op.
            if (MD_MULTI) begin
              w_pc_en        = 1'b0;
              w_if_id_en     = 1'b0;
              w_id_ex_en     = 1'b0;
              w_ex_mem_flush = 1'b1;
              w_state_nxt    = MD_BUSY;
              w_md_cnt_nxt   = MD_LOAD;
            end
          end else if (bus.ex_branch_taken) begin
            // The PC stays enabled so the redirect target loads.
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
          end else if (w_load_use) begin
            // One bubble: the load moves on to MEM, and the consumer
            // re-evaluates next cycle without the hazard.
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          if (r_md_cnt > 4'd1) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_flush = 1'b1;
            w_md_cnt_nxt   = r_md_cnt - 4'd1;
          end else begin
            // This is the last occupancy cycle. The result advances into
            // EX/MEM under the default controls.
            w_state_nxt  = RUN;
            w_md_cnt_nxt = 4'd0;
          end
        end
        default: begin
          w_state_nxt  = RUN;
          w_md_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // FSM state register and mul/div occupancy counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state  <= RUN;
      r_md_cnt <= 4'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_md_cnt <= w_md_cnt_nxt;
    end
  end

  // Memory wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      r_wait_cnt <= w_mem_stall ? (r_wait_cnt + 8'd1) : 8'd0;
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Count cycles in which the front end did not advance. The count wraps.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_stall_cycles <= 32'd0;
    end else if (!w_pc_en) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign bus.pc_en        = w_pc_en;
  assign bus.if_id_en     = w_if_id_en;
  assign bus.id_ex_en     = w_id_ex_en;
  assign bus.ex_mem_en    = w_ex_mem_en;
  assign bus.mem_wb_en    = w_mem_wb_en;
  assign bus.if_id_flush  = w_if_id_flush;
  assign bus.id_ex_flush  = w_id_ex_flush;
  assign bus.ex_mem_flush = w_ex_mem_flush;
  assign bus.md_busy      = rstn & (r_state == MD_BUSY);
  assign bus.mem_err      = r_mem_err;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.dbg_state    = r_state;
  assign bus.dbg_md_cnt   = r_md_cnt;
  assign bus.dbg_wait_cnt = r_wait_cnt;

endmodule
